// File: rtl/free_list_pkg.sv
// Shared constants and packet types for the rename-stage physical register free list.
package free_list_pkg;

    localparam int DEF_NUM_PR   = 64;
    localparam int DEF_NUM_ARCH = 32;
    localparam int DEF_NUM_ROB  = 32;
    localparam int DEF_ZERO_REG = 31;

    localparam int DEF_PR_W    = $clog2(DEF_NUM_PR);
    localparam int DEF_ARCH_W  = $clog2(DEF_NUM_ARCH);
    localparam int DEF_ROB_W   = $clog2(DEF_NUM_ROB);
    localparam int DEF_FL_SIZE = DEF_NUM_PR - DEF_NUM_ARCH;
    localparam int DEF_CNT_W   = $clog2(DEF_FL_SIZE + 1);

    // Bundled request side of the free list (dispatch, retire, rollback).
    typedef struct packed {
        logic                  dispatch_en;
        logic [DEF_ARCH_W-1:0] dispatch_dest_idx;
        logic [DEF_ROB_W-1:0]  dispatch_rob_idx;
        logic                  retire_en;
        logic [DEF_ARCH_W-1:0] retire_dest_idx;
        logic [DEF_PR_W-1:0]   t_old_idx_head;
        logic                  rollback_en;
        logic [DEF_ROB_W-1:0]  rob_rollback_idx;
    } freelist_packet_in_t;

    // Bundled response side of the free list.
    typedef struct packed {
        logic [DEF_PR_W-1:0]  t_idx;
        logic                 free_valid;
        logic [DEF_CNT_W-1:0] free_count;
    } freelist_packet_out_t;

endpackage

// File: rtl/free_list_chk.sv
// Simulation-only checker: a retire must never try to free into a full list.
module free_list_chk (
    input  logic clock_i,
    input  logic reset_i,
    input  logic free_req_i,
    input  logic full_i
);

    // Flag an overfill attempt; the free list itself ignores the request.
    always @(posedge clock_i) begin
        if (!reset_i) begin
            assert (!(free_req_i && full_i))
                else $error("free_list: free requested while the list is full");
        end
    end

endmodule

// File: rtl/free_list.sv
// R10000-style physical register free list with per-ROB-entry head checkpoints.
module free_list
    import free_list_pkg::*;
#(
    parameter  int NUM_PR   = DEF_NUM_PR,
    parameter  int NUM_ARCH = DEF_NUM_ARCH,
    parameter  int NUM_ROB  = DEF_NUM_ROB,
    parameter  int ZERO_REG = DEF_ZERO_REG,
    localparam int PR_W     = $clog2(NUM_PR),
    localparam int ARCH_W   = $clog2(NUM_ARCH),
    localparam int ROB_W    = $clog2(NUM_ROB),
    localparam int FL_SIZE  = NUM_PR - NUM_ARCH,
    localparam int FL_W     = $clog2(FL_SIZE),
    localparam int PTR_W    = FL_W + 1,
    localparam int CNT_W    = $clog2(FL_SIZE + 1)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic              dispatch_en_i,
    input  logic [ARCH_W-1:0] dispatch_dest_idx_i,
    input  logic [ROB_W-1:0]  dispatch_ROB_idx_i,
    input  logic              retire_en_i,
    input  logic [ARCH_W-1:0] retire_dest_idx_i,
    input  logic [PR_W-1:0]   T_old_idx_head_i,
    input  logic              rollback_en_i,
    input  logic [ROB_W-1:0]  ROB_rollback_idx_i,
    output logic [PR_W-1:0]   T_idx_o,
    output logic              free_valid_o,
    output logic [CNT_W-1:0]  free_count_o
`ifdef DEBUG
    ,
    output logic [FL_SIZE-1:0][PR_W-1:0] dbg_fl_o,
    output logic [PTR_W-1:0]             dbg_head_o,
    output logic [PTR_W-1:0]             dbg_tail_o
`endif
);

    logic [PR_W-1:0]  fl_q   [FL_SIZE];
    logic [PTR_W-1:0] ckpt_q [NUM_ROB];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_s;
    logic             full_s;
    logic             alloc_s;
    logic             free_req_s;
    logic             free_s;
    logic             ckpt_we_s;

    // Advance a pointer; the wrap bit toggles when the index passes the last slot.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p[FL_W-1:0] == FL_W'(FL_SIZE - 1)) begin
            r[PTR_W-1]  = ~p[PTR_W-1];
            r[FL_W-1:0] = '0;
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Occupancy from registered pointers, correct for any FL_SIZE.
    always_comb begin
        if (head_q[PTR_W-1] == tail_q[PTR_W-1]) begin
            count_s = CNT_W'(tail_q[FL_W-1:0]) - CNT_W'(head_q[FL_W-1:0]);
        end else begin
            count_s = CNT_W'(FL_SIZE) - CNT_W'(head_q[FL_W-1:0]) + CNT_W'(tail_q[FL_W-1:0]);
        end
    end

    assign full_s       = (count_s == CNT_W'(FL_SIZE));
    assign free_valid_o = (count_s != CNT_W'(0));
    assign free_count_o = count_s;
    assign T_idx_o      = fl_q[head_q[FL_W-1:0]];

    assign alloc_s    = en_i & dispatch_en_i & free_valid_o & ~rollback_en_i
                        & (dispatch_dest_idx_i != ARCH_W'(ZERO_REG));
    assign free_req_s = en_i & retire_en_i & (retire_dest_idx_i != ARCH_W'(ZERO_REG));
    assign free_s     = free_req_s & ~full_s;
    assign ckpt_we_s  = en_i & dispatch_en_i & ~rollback_en_i;

    // Next head/tail: rollback overrides dispatch; tail moves independently on retire.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (en_i && rollback_en_i) begin
            head_d = ckpt_q[ROB_rollback_idx_i];
        end else if (alloc_s) begin
            head_d = ptr_inc(head_q);
        end else begin
            head_d = head_q;
        end
        if (free_s) begin
            tail_d = ptr_inc(tail_q);
        end else begin
            tail_d = tail_q;
        end
    end

    // State registers: list contents, pointers and per-ROB head checkpoints.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            head_q <= '0;
            tail_q <= {1'b1, {FL_W{1'b0}}};
            for (int i = 0; i < FL_SIZE; i++) begin
                fl_q[i] <= PR_W'(NUM_ARCH + i);
            end
            for (int j = 0; j < NUM_ROB; j++) begin
                ckpt_q[j] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            if (free_s) begin
                fl_q[tail_q[FL_W-1:0]] <= T_old_idx_head_i;
            end
            if (ckpt_we_s) begin
                ckpt_q[dispatch_ROB_idx_i] <= head_d;
            end
        end
    end

`ifdef DEBUG
    // Flatten internal state for debug visibility.
    always_comb begin
        for (int k = 0; k < FL_SIZE; k++) begin
            dbg_fl_o[k] = fl_q[k];
        end
    end
    assign dbg_head_o = head_q;
    assign dbg_tail_o = tail_q;
`endif

    free_list_chk u_chk (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .free_req_i (free_req_s),
        .full_i     (full_s)
    );

endmodule

// File: tb/tb_free_list.sv
// Directed self-checking bench for the free list.
module tb_free_list;

    logic       clk;
    logic       reset;
    logic       en;
    logic       dispatch_en;
    logic [4:0] dispatch_dest;
    logic [4:0] dispatch_rob;
    logic       retire_en;
    logic [4:0] retire_dest;
    logic [5:0] t_old;
    logic       rollback_en;
    logic [4:0] rollback_idx;
    logic [5:0] t_idx;
    logic       free_valid;
    logic [5:0] free_count;

    int checks   = 0;
    int failures = 0;

    free_list dut (
        .clock_i             (clk),
        .reset_i             (reset),
        .en_i                (en),
        .dispatch_en_i       (dispatch_en),
        .dispatch_dest_idx_i (dispatch_dest),
        .dispatch_ROB_idx_i  (dispatch_rob),
        .retire_en_i         (retire_en),
        .retire_dest_idx_i   (retire_dest),
        .T_old_idx_head_i    (t_old),
        .rollback_en_i       (rollback_en),
        .ROB_rollback_idx_i  (rollback_idx),
        .T_idx_o             (t_idx),
        .free_valid_o        (free_valid),
        .free_count_o        (free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            end
    endtask

    task automatic chk_out(input string tag, input int exp_t, input int exp_v, input int exp_c);
        chk({tag, "_T_idx"}, 32'(t_idx), 32'(exp_t));
        chk({tag, "_free_valid"}, 32'(free_valid), 32'(exp_v));
        chk({tag, "_free_count"}, 32'(free_count), 32'(exp_c));
    endtask

    task automatic idle();
        dispatch_en   = 1'b0;
        dispatch_dest = 5'd0;
        dispatch_rob  = 5'd0;
        retire_en     = 1'b0;
        retire_dest   = 5'd0;
        t_old         = 6'd0;
        rollback_en   = 1'b0;
        rollback_idx  = 5'd0;
    endtask

    initial begin
        en    = 1'b1;
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        chk_out("reset", 32, 1, 32);

        // Dispatch to ZERO_REG: no allocation, checkpoint of ROB 5 = 0.
        dispatch_en = 1'b1; dispatch_dest = 5'd31; dispatch_rob = 5'd5;
        step(); idle();
        chk_out("zero_dest", 32, 1, 32);

        // Four allocators at ROB 0..3.
        for (int i = 0; i < 4; i++) begin
            chk("alloc4_seq", 32'(t_idx), 32'(32 + i));
            dispatch_en = 1'b1; dispatch_dest = 5'd1; dispatch_rob = 5'(i);
            step();
        end
        idle();
        chk_out("alloc4", 36, 1, 28);

        // Rollback to ROB 1 with a competing dispatch that must be ignored.
        rollback_en = 1'b1; rollback_idx = 5'd1;
        dispatch_en = 1'b1; dispatch_dest = 5'd1; dispatch_rob = 5'd7;
        step(); idle();
        chk_out("rollback1", 34, 1, 30);

        // Rollback to the ZERO_REG dispatch's checkpoint restores head 0.
        rollback_en = 1'b1; rollback_idx = 5'd5;
        step(); idle();
        chk_out("rollback_zero", 32, 1, 32);

        // Drain the whole list.
        for (int i = 0; i < 32; i++) begin
            chk("drain_T_idx", 32'(t_idx), 32'(32 + i));
            chk("drain_count", 32'(free_count), 32'(32 - i));
            dispatch_en = 1'b1; dispatch_dest = 5'd1; dispatch_rob = 5'(i);
            step();
        end
        idle();
        chk("empty_valid", 32'(free_valid), 32'd0);
        chk("empty_count", 32'(free_count), 32'd0);

        // Retire into an empty list while a dispatch is attempted: no bypass.
        retire_en = 1'b1; retire_dest = 5'd3; t_old = 6'd5;
        dispatch_en = 1'b1; dispatch_dest = 5'd1; dispatch_rob = 5'd0;
        step(); idle();
        chk_out("retire_empty", 5, 1, 1);

        // Retire of ZERO_REG frees nothing.
        retire_en = 1'b1; retire_dest = 5'd31; t_old = 6'd9;
        step(); idle();
        chk_out("retire_zero", 5, 1, 1);

        // Global stall freezes everything.
        en = 1'b0;
        dispatch_en = 1'b1; dispatch_dest = 5'd1; dispatch_rob = 5'd2;
        retire_en = 1'b1; retire_dest = 5'd2; t_old = 6'd12;
        rollback_en = 1'b1; rollback_idx = 5'd2;
        step(); idle();
        en = 1'b1;
        chk_out("stall", 5, 1, 1);

        // Refill to full-minus-one: tail ends at 63.
        for (int i = 0; i < 30; i++) begin
            retire_en = 1'b1; retire_dest = 5'd2; t_old = 6'(10 + i);
            step();
        end
        idle();
        chk_out("refill", 5, 1, 31);

        // Simultaneous alloc and free: count unchanged, tail wraps 63 -> 0.
        dispatch_en = 1'b1; dispatch_dest = 5'd1; dispatch_rob = 5'd3;
        retire_en = 1'b1; retire_dest = 5'd2; t_old = 6'd50;
        step(); idle();
        chk_out("alloc_free", 10, 1, 31);

        // Drain again: the last entry is the PR written just before the wrap.
        for (int i = 0; i < 31; i++) begin
            chk("wrap_seq", 32'(t_idx), (i < 30) ? 32'(10 + i) : 32'd50);
            dispatch_en = 1'b1; dispatch_dest = 5'd1; dispatch_rob = 5'(i);
            step();
        end
        idle();
        chk("wrap_empty_count", 32'(free_count), 32'd0);

        // Free after head wrap lands in slot 0.
        retire_en = 1'b1; retire_dest = 5'd4; t_old = 6'd7;
        step(); idle();
        chk_out("head_wrap", 7, 1, 1);

        // Reset during rollback, dispatch and retire.
        reset = 1'b1;
        dispatch_en = 1'b1; dispatch_dest = 5'd1; dispatch_rob = 5'd4;
        retire_en = 1'b1; retire_dest = 5'd2; t_old = 6'd3;
        rollback_en = 1'b1; rollback_idx = 5'd3;
        step();
        reset = 1'b0;
        idle();
        chk_out("reset_mid", 32, 1, 32);

        // Contents re-initialised by reset.
        dispatch_en = 1'b1; dispatch_dest = 5'd1; dispatch_rob = 5'd0;
        step(); idle();
        chk_out("post_reset_alloc", 33, 1, 31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
